// File: rtl/diram_phy_responder.sv
// DRAM-side endpoint for the DiRAM PHY command/data interface: decodes commands, stores write bursts, returns read bursts.
// Optional: define DIRAM_PHY_RSP_PAGE_CHECK_EN to drop RD/WR to closed banks and flag ACT to open banks.
module diram_phy_rsp_burst #(
    parameter int LAT       = 1,
    parameter int BURST_LEN = 4,
    parameter int IDX_W     = 10,
    parameter int COL_W     = 6
) (
    input  logic             clk,
    input  logic             reset_poweron,
    input  logic             start,
    input  logic [IDX_W-1:0] req,
    output logic             beat_v,
    output logic [IDX_W-1:0] beat_idx
);
    localparam int CNT_W = $clog2(BURST_LEN) + 1;

    logic             dly_v [LAT];
    logic [IDX_W-1:0] dly   [LAT];
    logic             active;
    logic [CNT_W-1:0] beat;
    logic [IDX_W-1:0] cur;
    logic [IDX_W-1:0] base;
    logic [COL_W-1:0] offs;

    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            for (int i = 0; i < LAT; i++) dly_v[i] <= 1'b0;
            active <= 1'b0;
            beat   <= '0;
        end else begin
            dly_v[0] <= start;
            for (int i = 1; i < LAT; i++) dly_v[i] <= dly_v[i-1];
            // The delay-line tail issues beat 0 itself; the counter covers the remaining beats.
            if (dly_v[LAT-1]) begin
                active <= (BURST_LEN > 1);
                beat   <= CNT_W'(1);
                cur    <= dly[LAT-1];
            end else if (active) begin
                beat <= beat + CNT_W'(1);
                if (beat == CNT_W'(BURST_LEN - 1)) active <= 1'b0;
            end
        end
        dly[0] <= req;
        for (int i = 1; i < LAT; i++) dly[i] <= dly[i-1];
    end

    always_comb begin
        base = cur;
        offs = COL_W'(beat);
        if (dly_v[LAT-1]) begin
            base = dly[LAT-1];
            offs = '0;
        end
    end

    // Column wraps inside its own field; bank and row bits pass through untouched.
    assign beat_v   = dly_v[LAT-1] || active;
    assign beat_idx = {base[IDX_W-1:COL_W], base[COL_W-1:0] + offs};
endmodule

module diram_phy_responder #(
    parameter int DATA_W    = 64,
    parameter int NUM_BANKS = 4,
    parameter int BANK_W    = 2,
    parameter int ADDR_W    = 12,
    parameter int ROW_IDX_W = 2,
    parameter int COL_W     = 6,
    parameter int BURST_LEN = 4,
    parameter int RD_LAT    = 3,
    parameter int WR_LAT    = 1
) (
    input  logic              clk,
    input  logic              reset_poweron,
    input  logic              dfi__phy__cs,
    input  logic              dfi__phy__cmd1,
    input  logic              dfi__phy__cmd0,
    input  logic [BANK_W-1:0] dfi__phy__bank,
    input  logic [ADDR_W-1:0] dfi__phy__addr,
    input  logic [DATA_W-1:0] dfi__phy__data,
    output logic              phy__dfi__valid,
    output logic [DATA_W-1:0] phy__dfi__data,
    output logic              phy__err,
    output logic [1:0]        phy__err_code
);
    localparam int IDX_W = BANK_W + ROW_IDX_W + COL_W;
    localparam int CNT_W = $clog2(BURST_LEN) + 1;

    logic [DATA_W-1:0]    mem      [1 << IDX_W];
    logic [ROW_IDX_W-1:0] bank_row [NUM_BANKS];
    logic [CNT_W-1:0]     space_cnt;
    logic                 is_act, is_pre, is_rw;
    logic                 spacing_hit, page_hit, rw_accept;
    logic [1:0]           page_code;
    logic [IDX_W-1:0]     cmd_req, rd_idx, wr_idx;
    logic                 rd_beat_v, wr_beat_v;
    logic                 unused_bits;

    assign is_act      = dfi__phy__cs && !dfi__phy__cmd1 && !dfi__phy__cmd0;
    assign is_pre      = dfi__phy__cs &&  dfi__phy__cmd1 &&  dfi__phy__cmd0;
    assign is_rw       = dfi__phy__cs && (dfi__phy__cmd1 != dfi__phy__cmd0);
    assign spacing_hit = is_rw && (space_cnt != '0);
    assign rw_accept   = is_rw && !spacing_hit && !page_hit;
    // Only the low row bits select storage, so only those are tracked per bank.
    assign cmd_req     = {dfi__phy__bank, bank_row[dfi__phy__bank], dfi__phy__addr[COL_W-1:0]};

`ifdef DIRAM_PHY_RSP_PAGE_CHECK_EN
    logic [NUM_BANKS-1:0] bank_open;

    assign page_hit    = (is_rw && !spacing_hit && !bank_open[dfi__phy__bank]) ||
                         (is_act && bank_open[dfi__phy__bank]);
    assign page_code   = is_act ? 2'd3 : 2'd2;
    assign unused_bits = ^dfi__phy__addr[ADDR_W-1:COL_W];

    always_ff @(posedge clk) begin
        if (reset_poweron)  bank_open <= '0;
        else if (is_act)    bank_open[dfi__phy__bank] <= 1'b1;
        else if (is_pre)    bank_open[dfi__phy__bank] <= 1'b0;
    end
`else
    assign page_hit    = 1'b0;
    assign page_code   = 2'd0;
    assign unused_bits = ^{dfi__phy__addr[ADDR_W-1:COL_W], is_pre};
`endif

    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            for (int i = 0; i < NUM_BANKS; i++) bank_row[i] <= '0;
            space_cnt     <= '0;
            phy__err      <= 1'b0;
            phy__err_code <= 2'd0;
        end else begin
            if (is_act) bank_row[dfi__phy__bank] <= dfi__phy__addr[ROW_IDX_W-1:0];
            if (rw_accept)              space_cnt <= CNT_W'(BURST_LEN - 1);
            else if (space_cnt != '0)   space_cnt <= space_cnt - CNT_W'(1);
            if (!phy__err && (spacing_hit || page_hit)) begin
                phy__err      <= 1'b1;
                phy__err_code <= spacing_hit ? 2'd1 : page_code;
            end
        end
    end

    diram_phy_rsp_burst #(.LAT(RD_LAT), .BURST_LEN(BURST_LEN), .IDX_W(IDX_W), .COL_W(COL_W)) u_rd (
        .clk(clk), .reset_poweron(reset_poweron), .start(rw_accept && !dfi__phy__cmd1),
        .req(cmd_req), .beat_v(rd_beat_v), .beat_idx(rd_idx)
    );

    diram_phy_rsp_burst #(.LAT(WR_LAT), .BURST_LEN(BURST_LEN), .IDX_W(IDX_W), .COL_W(COL_W)) u_wr (
        .clk(clk), .reset_poweron(reset_poweron), .start(rw_accept && dfi__phy__cmd1),
        .req(cmd_req), .beat_v(wr_beat_v), .beat_idx(wr_idx)
    );

    // Storage keeps its contents across reset; a same-edge read sees the pre-write word.
    always_ff @(posedge clk) begin
        if (!reset_poweron && wr_beat_v) mem[wr_idx] <= dfi__phy__data;
    end

    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            phy__dfi__valid <= 1'b0;
            phy__dfi__data  <= '0;
        end else begin
            phy__dfi__valid <= rd_beat_v;
            phy__dfi__data  <= rd_beat_v ? mem[rd_idx] : '0;
        end
    end
endmodule
